// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: controller redirect/hold controls, instruction memory port and IF/ID outputs.
// Purely structural; carries no state and adds no latency.
// No handshake: stall holds the stage, killF flushes IF/ID.
// Optional FETCH_PERF_EN adds the three performance counter outputs.
interface fetch_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);

  // Controller -> fetch
  logic              stall;
  logic              killF;
  logic [1:0]        PCSrc;
  logic              PCsrcJType;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] for_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] ret_addr;

  // Instruction memory port (combinational read)
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;

  // IF/ID pipeline buffer
  logic [INSTR_W-1:0] IDInstr;
  logic [ADDR_W-1:0]  IDPCplus1;
  logic               IDValid;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_killed;
  logic [15:0] perf_stalled;
`endif

  // Fetch stage side
  modport slave (
    input  stall, killF, PCSrc, PCsrcJType,
    input  branch_target, for_target, jump_target, ret_addr,
    input  imem_data,
    output imem_addr,
    output IDInstr, IDPCplus1, IDValid
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_killed, perf_stalled
`endif
  );

  // Controller / memory / environment side
  modport master (
    output stall, killF, PCSrc, PCsrcJType,
    output branch_target, for_target, jump_target, ret_addr,
    output imem_data,
    input  imem_addr,
    input  IDInstr, IDPCplus1, IDValid
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_killed, perf_stalled
`endif
  );

endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, imem address drive, IF/ID buffer.
// Latency: instruction at PC=A appears on IDInstr one cycle later; imem_addr is combinational from PC.
// Backpressure: stall holds PC and IF/ID; killF (when not stalled) redirects and flushes IF/ID to NOP.
// Optional macro FETCH_PERF_EN adds saturating fetched/killed/stalled cycle counters.
module fetch_stage #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic        clk,
  input  logic        reset,
  fetch_stage_if.slave bus
);

  // PCSrc encodings
  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_FOR    = 2'b10;
  localparam logic [1:0] SRC_JTYPE  = 2'b11;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  next_pc;

  logic [INSTR_W-1:0] id_instr_q;
  logic [ADDR_W-1:0]  id_pcplus1_q;
  logic               id_valid_q;

  // Stage activity classes; stall dominates killF.
  logic advance;
  logic do_fetch;
  logic do_kill;

  assign advance  = ~bus.stall;
  assign do_fetch = advance & ~bus.killF;
  assign do_kill  = advance &  bus.killF;

  // Sequential successor; wraps silently from all-ones to zero.
  assign pc_plus1 = pc_q + ONE;

  // Next-PC mux driven by the controller's select lines.
  always_comb begin
    next_pc = pc_plus1;
    unique case (bus.PCSrc)
      SRC_SEQ:    next_pc = pc_plus1;
      SRC_BRANCH: next_pc = bus.branch_target;
      SRC_FOR:    next_pc = bus.for_target;
      SRC_JTYPE:  next_pc = bus.PCsrcJType ? bus.ret_addr : bus.jump_target;
      default:    next_pc = pc_plus1;
    endcase
  end

  // PC register: reset wins, stall holds, otherwise follow next-PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (advance) begin
      pc_q <= next_pc;
    end
  end

  // IF/ID buffer: capture the fetched word, or inject a bubble on kill.
  // PCSrc != SEQ without killF still captures the fetched word; the
  // controller never issues that combination.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr_q   <= NOP_INSTR;
      id_pcplus1_q <= '0;
      id_valid_q   <= 1'b0;
    end else if (do_kill) begin
      id_instr_q   <= NOP_INSTR;
      id_pcplus1_q <= pc_plus1;
      id_valid_q   <= 1'b0;
    end else if (do_fetch) begin
      id_instr_q   <= bus.imem_data;
      id_pcplus1_q <= pc_plus1;
      id_valid_q   <= 1'b1;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.IDInstr   = id_instr_q;
  assign bus.IDPCplus1 = id_pcplus1_q;
  assign bus.IDValid   = id_valid_q;

`ifdef FETCH_PERF_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [15:0] perf_fetched_q;
  logic [15:0] perf_killed_q;
  logic [15:0] perf_stalled_q;

  // Saturating activity counters; reset cycles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
      perf_stalled_q <= '0;
    end else begin
      if (do_fetch && (perf_fetched_q != CNT_MAX)) begin
        perf_fetched_q <= perf_fetched_q + 16'd1;
      end
      if (do_kill && (perf_killed_q != CNT_MAX)) begin
        perf_killed_q <= perf_killed_q + 16'd1;
      end
      if (bus.stall && (perf_stalled_q != CNT_MAX)) begin
        perf_stalled_q <= perf_stalled_q + 16'd1;
      end
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_killed  = perf_killed_q;
  assign bus.perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a per-cycle scoreboard.
// The memory model returns 16'h1000 + address combinationally.
module tb_fetch_stage;

  localparam int          AW  = 16;
  localparam int          IW  = 16;
  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [15:0] NOP = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp1;
    logic        valid;
    logic        chk_pcp1;
  } exp_t;

  logic clk;
  logic reset;

  fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_stage #(
    .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC), .NOP_INSTR(NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.imem_data = 16'h1000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference state
  logic [15:0] m_pc, m_instr, m_pcp1;
  logic        m_valid;
  int          m_fetched = 0, m_killed = 0, m_stalled = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic step(input logic st, input logic kl, input logic [1:0] src,
                      input logic jt, input logic rst);
    exp_t        e;
    logic [15:0] nxt;
    reset          = rst;
    bus.stall      = st;
    bus.killF      = kl;
    bus.PCSrc      = src;
    bus.PCsrcJType = jt;
    case (src)
      2'b00:   nxt = m_pc + 16'd1;
      2'b01:   nxt = bus.branch_target;
      2'b10:   nxt = bus.for_target;
      default: nxt = jt ? bus.ret_addr : bus.jump_target;
    endcase
    if (rst) begin
      m_pc = RPC; m_instr = NOP; m_pcp1 = 16'h0; m_valid = 1'b0;
      m_fetched = 0; m_killed = 0; m_stalled = 0;
      e.chk_pcp1 = 1'b1;
    end else if (st) begin
      e.chk_pcp1 = m_valid;
      m_stalled = (m_stalled < 65535) ? m_stalled + 1 : m_stalled;
    end else if (kl) begin
      m_pcp1 = m_pc + 16'd1; m_instr = NOP; m_valid = 1'b0; m_pc = nxt;
      e.chk_pcp1 = 1'b0;
      m_killed = (m_killed < 65535) ? m_killed + 1 : m_killed;
    end else begin
      m_instr = 16'h1000 + m_pc; m_pcp1 = m_pc + 16'd1; m_valid = 1'b1; m_pc = nxt;
      e.chk_pcp1 = 1'b1;
      m_fetched = (m_fetched < 65535) ? m_fetched + 1 : m_fetched;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcp1 = m_pcp1; e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pc", bus.imem_addr, e.pc);
      chk("sb_valid", bus.IDValid, e.valid);
      chk("sb_instr", bus.IDInstr, e.instr);
      if (e.chk_pcp1) chk("sb_pcp1", bus.IDPCplus1, e.pcp1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.killF = 1'b0; bus.PCSrc = 2'b00; bus.PCsrcJType = 1'b0;
    bus.branch_target = 16'h0040; bus.for_target = 16'h0012;
    bus.jump_target = 16'h0020; bus.ret_addr = 16'h0033;
    m_pc = 16'h0; m_instr = 16'h0; m_pcp1 = 16'h0; m_valid = 1'b0;
    #1;

    // Reset state
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 1);
    chk("rst_pc", bus.imem_addr, 16'h0000);
    chk("rst_valid", bus.IDValid, 0);
    chk("rst_instr", bus.IDInstr, NOP);
    chk("rst_pcp1", bus.IDPCplus1, 16'h0000);

    // Four free-running fetches
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 2'b00, 0, 0);
      chk("seq_instr", bus.IDInstr, 16'h1000 + i);
      chk("seq_pcp1", bus.IDPCplus1, i + 1);
      chk("seq_valid", bus.IDValid, 1);
    end
    step(0, 0, 2'b00, 0, 0);
    chk("pc5", bus.imem_addr, 16'h0005);

    // Branch redirect with flush
    step(0, 1, 2'b01, 0, 0);
    chk("br_pc", bus.imem_addr, 16'h0040);
    chk("br_nop", bus.IDInstr, NOP);
    chk("br_valid", bus.IDValid, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("br_instr", bus.IDInstr, 16'h1040);
    chk("br_pcp1", bus.IDPCplus1, 16'h0041);

    // J-type and FOR selection
    step(0, 1, 2'b11, 0, 0);
    chk("jmp_pc", bus.imem_addr, 16'h0020);
    step(0, 1, 2'b11, 1, 0);
    chk("ret_pc", bus.imem_addr, 16'h0033);
    step(0, 1, 2'b10, 0, 0);
    chk("for_pc", bus.imem_addr, 16'h0012);

    // Stall dominates kill and redirect
    step(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'b01, 0, 0);
      chk("stl_pc", bus.imem_addr, 16'h0013);
      chk("stl_instr", bus.IDInstr, 16'h1012);
      chk("stl_valid", bus.IDValid, 1);
      chk("stl_pcp1", bus.IDPCplus1, 16'h0013);
    end
    step(0, 1, 2'b01, 0, 0);
    chk("stl_redir", bus.imem_addr, 16'h0040);
    chk("stl_flush", bus.IDValid, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("stl_after", bus.imem_addr, 16'h0041);

    // PC wrap
    bus.jump_target = 16'hFFFF;
    step(0, 1, 2'b11, 0, 0);
    chk("wrap_pre", bus.imem_addr, 16'hFFFF);
    step(0, 0, 2'b00, 0, 0);
    chk("wrap_pc", bus.imem_addr, 16'h0000);
    chk("wrap_pcp1", bus.IDPCplus1, 16'h0000);
    chk("wrap_instr", bus.IDInstr, 16'h0FFF);

    // Reset during a stall
    step(0, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    step(1, 1, 2'b01, 0, 1);
    chk("rst_stl_pc", bus.imem_addr, RPC);
    chk("rst_stl_valid", bus.IDValid, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("rst_first", bus.IDInstr, 16'h1000);
    chk("rst_first_v", bus.IDValid, 1);

`ifdef FETCH_PERF_EN
    step(0, 0, 2'b00, 0, 1);
    chk("perf_rst", bus.perf_fetched, 16'h0000);
    for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 0);
    chk("perf_f", bus.perf_fetched, 16'd10);
    chk("perf_k", bus.perf_killed, 16'd2);
    chk("perf_s", bus.perf_stalled, 16'd3);
    chk("perf_f_model", bus.perf_fetched, m_fetched);
    for (int i = 0; i < 70000; i++) step(0, 0, 2'b00, 0, 0);
    chk("perf_sat", bus.perf_fetched, 16'hFFFF);
    chk("perf_k_hold", bus.perf_killed, 16'd2);
    chk("perf_s_hold", bus.perf_stalled, 16'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
